// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative radix-2 multiply/divide unit for the Execute stage
// Optional MDU_EARLY_OUT_EN: x/0, signed overflow and multiply-by-zero bypass CALC/FIX.
module mdu_iter #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [TAGW-1:0] rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [TAGW-1:0] rd_o
);

  localparam int countW = $clog2(XLEN);
  localparam logic [XLEN-1:0] minNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

  stateT               state;
  logic [countW-1:0]   count;
  logic [2:0]          opQ;
  logic [TAGW-1:0]     rdQ;
  logic                signA, signB, divZero, divOvf;
  logic [XLEN-1:0]     bMag, aRaw;
  logic [2*XLEN-1:0]   acc;
  logic                validQ, busyQ;
  logic [XLEN-1:0]     resultQ;
  logic [TAGW-1:0]     rdOutQ;

  // Operand decode for a new request
  logic            inIsDiv, inSigned, inNegA, inNegB, inDivZero, inDivOvf;
  logic [XLEN-1:0] inMagA, inMagB;

  assign inIsDiv   = op_i[2];
  assign inSigned  = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
  assign inNegA    = inSigned && a_i[XLEN-1];
  assign inNegB    = inSigned && b_i[XLEN-1];
  assign inMagA    = inNegA ? -a_i : a_i;
  assign inMagB    = inNegB ? -b_i : b_i;
  assign inDivZero = inIsDiv && (b_i == '0);
  assign inDivOvf  = inIsDiv && inSigned && (a_i == minNeg) && (b_i == '1);

  logic            inEarly;
  logic [XLEN-1:0] inEarlyResult;

`ifdef MDU_EARLY_OUT_EN
  always_comb begin
    inEarly       = 1'b0;
    inEarlyResult = '0;
    if (inDivZero) begin
      inEarly       = 1'b1;
      inEarlyResult = op_i[1] ? a_i : '1;
    end else if (inDivOvf) begin
      inEarly       = 1'b1;
      inEarlyResult = op_i[1] ? '0 : a_i;
    end else if (!inIsDiv && ((a_i == '0) || (b_i == '0))) begin
      inEarly       = 1'b1;
    end
  end
`else
  assign inEarly       = 1'b0;
  assign inEarlyResult = '0;
`endif

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  // Divide keeps the partial remainder in the upper half and shifts quotient bits into the lower half.
  logic [XLEN:0]     mulSum, remShift, remDiff;
  logic [2*XLEN-1:0] accNext;

  always_comb begin
    mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bMag} : '0);
    remShift = acc[2*XLEN-1:XLEN-1];
    remDiff  = remShift - {1'b0, bMag};
    if (opQ[2]) begin
      if (remDiff[XLEN])
        accNext = {remShift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        accNext = {remDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      accNext = {mulSum, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prodSigned;
  logic [XLEN-1:0]   quot, rem, fixResult;

  always_comb begin
    prodSigned = (signA ^ signB) ? -acc : acc;
    quot       = (signA ^ signB) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem        = signA ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fixResult  = '0;
    if (opQ[2]) begin
      if (divZero)
        fixResult = opQ[1] ? aRaw : '1;
      else if (divOvf)
        fixResult = opQ[1] ? '0 : aRaw;
      else
        fixResult = opQ[1] ? rem : quot;
    end else if (opQ[1:0] == 2'b01 || opQ[1:0] == 2'b10) begin
      fixResult = prodSigned[2*XLEN-1:XLEN];
    end else begin
      fixResult = prodSigned[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      opQ     <= '0;
      rdQ     <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
      divOvf  <= 1'b0;
      bMag    <= '0;
      aRaw    <= '0;
      acc     <= '0;
      validQ  <= 1'b0;
      busyQ   <= 1'b0;
      resultQ <= '0;
      rdOutQ  <= '0;
    end else begin
      validQ <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i && !flush_i) begin
            opQ     <= op_i;
            rdQ     <= rd_i;
            signA   <= inNegA;
            signB   <= inNegB;
            divZero <= inDivZero;
            divOvf  <= inDivOvf;
            bMag    <= inMagB;
            aRaw    <= a_i;
            acc     <= {{XLEN{1'b0}}, inMagA};
            if (inEarly) begin
              state   <= DONE;
              resultQ <= inEarlyResult;
              rdOutQ  <= rd_i;
              validQ  <= 1'b1;
              busyQ   <= 1'b0;
            end else begin
              state <= CALC;
              count <= countW'(XLEN - 1);
              busyQ <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busyQ <= 1'b0;
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
            busyQ <= 1'b0;
          end else begin
            acc   <= accNext;
            count <= count - countW'(1);
            if (count == '0)
              state <= FIX;
          end
        end
        FIX: begin
          busyQ <= 1'b0;
          if (flush_i) begin
            state <= IDLE;
          end else begin
            state   <= DONE;
            resultQ <= fixResult;
            rdOutQ  <= rdQ;
            validQ  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busyQ <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving during the DONE cycle must still be able to kill the strobe.
  assign valid_o  = validQ && !flush_i;
  assign busy_o   = busyQ;
  assign result_o = resultQ;
  assign rd_o     = rdOutQ;

endmodule
